xram_arbiter: RTL and testbench

Three-way arbiter sharing the single XRAM port between the oc8051 CPU, the AES accelerator and the SHA accelerator. It sits between the address-decoded XRAM-bound CPU bus, the accelerators' `xram_*` master ports, and the XRAM slave. It serves one strobe/ack transfer at a time. Ownership rotates round-robin, with a bounded burst per grant, so no requester starves.

---
 rtl/xram_arb_pkg.sv | 19 +
 rtl/xram_arbiter_rr_pick3.sv | 32 +++
 rtl/xram_arbiter.sv | 127 ++++++++++++
 tb/tb_xram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xram_arb_pkg.sv
// Shared encodings for the XRAM arbiter: owner ids, FSM states, ring successor.
// Pure declarations; no logic, no latency, no flow control.
package xram_arb_pkg;

  localparam logic [1:0] OWN_CPU = 2'd0;
  localparam logic [1:0] OWN_AES = 2'd1;
  localparam logic [1:0] OWN_SHA = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Successor in the cpu -> aes -> sha -> cpu ring; the unused code 3 maps to cpu.
  function automatic logic [1:0] next_owner(input logic [1:0] o);
    return (o == OWN_CPU) ? OWN_AES : (o == OWN_AES) ? OWN_SHA : OWN_CPU;
  endfunction

endpackage

// File: rtl/xram_arbiter_rr_pick3.sv
// Round-robin pick among three requesters, searching from ptr along the ring.
// Purely combinational; does not hold or stall anything.
module rr_pick3
  import xram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] start;

  assign start = (ptr == 2'd3) ? OWN_CPU : ptr;
  assign any   = |req;

  always_comb begin
    logic [1:0] cand;
    logic       found;
    winner = OWN_CPU;
    found  = 1'b0;
    cand   = start;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
      cand = next_owner(cand);
    end
  end

endmodule

// File: rtl/xram_arbiter.sv
// Shares the XRAM port between cpu, aes and sha with round-robin bounded bursts.
// Grant one cycle after a strobe in IDLE; acks combinational from xram_ack; losers wait with ack low.
module xram_arbiter
  import xram_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] aes_addr,
  input  logic [ADDR_W-1:0] sha_addr,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic [DATA_W-1:0] aes_data_out,
  input  logic [DATA_W-1:0] sha_data_out,
  input  logic              cpu_wr,
  input  logic              aes_wr,
  input  logic              sha_wr,
  input  logic              cpu_stb,
  input  logic              aes_stb,
  input  logic              sha_stb,
  output logic              cpu_ack,
  output logic              aes_ack,
  output logic              sha_ack,
  output logic [DATA_W-1:0] req_data_in,
  output logic [ADDR_W-1:0] xram_addr,
  output logic [DATA_W-1:0] xram_data_out,
  output logic              xram_wr,
  output logic              xram_stb,
  input  logic [DATA_W-1:0] xram_data_in,
  input  logic              xram_ack,
  output logic [1:0]        owner,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_e        state, state_nxt;
  logic [1:0]    owner_nxt, rr_ptr, rr_ptr_nxt, win;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt, beat_inc;
  logic          any_req, own_stb, hit;

  rr_pick3 u_pick (
    .req    ({sha_stb, aes_stb, cpu_stb}),
    .ptr    (rr_ptr),
    .winner (win),
    .any    (any_req)
  );

  always_comb begin
    own_stb       = cpu_stb;
    xram_addr     = cpu_addr;
    xram_data_out = cpu_data_out;
    xram_wr       = cpu_wr;
    case (owner)
      OWN_AES: begin
        own_stb       = aes_stb;
        xram_addr     = aes_addr;
        xram_data_out = aes_data_out;
        xram_wr       = aes_wr;
      end
      OWN_SHA: begin
        own_stb       = sha_stb;
        xram_addr     = sha_addr;
        xram_data_out = sha_data_out;
        xram_wr       = sha_wr;
      end
      default: ;
    endcase
  end

  assign busy        = (state == ST_GRANT);
  assign xram_stb    = busy & own_stb;
  assign hit         = xram_stb & xram_ack;
  assign cpu_ack     = hit & (owner == OWN_CPU);
  assign aes_ack     = hit & (owner == OWN_AES);
  assign sha_ack     = hit & (owner == OWN_SHA);
  assign req_data_in = xram_data_in;
  assign beat_inc    = beat_cnt + CW'(1);

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt    = ST_GRANT;
          owner_nxt    = win;
          beat_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!own_stb) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = next_owner(owner);
        end else if (xram_ack) begin
          beat_cnt_nxt = beat_inc;
          // Burst quota exhausted: hand the port to the next requester in the ring.
          if (beat_inc == CW'(MAX_BURST)) begin
            state_nxt  = ST_IDLE;
            rr_ptr_nxt = next_owner(owner);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_CPU;
      rr_ptr   <= OWN_CPU;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_xram_arbiter.sv
// Directed bench for xram_arbiter: single read, contention, bursts, stb drop, stray ack, reset.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_xram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cpu_addr, aes_addr, sha_addr;
  logic [DW-1:0] cpu_data_out, aes_data_out, sha_data_out;
  logic          cpu_wr, aes_wr, sha_wr;
  logic          cpu_stb, aes_stb, sha_stb;
  logic          cpu_ack, aes_ack, sha_ack;
  logic [DW-1:0] req_data_in;
  logic [AW-1:0] xram_addr;
  logic [DW-1:0] xram_data_out;
  logic          xram_wr, xram_stb;
  logic [DW-1:0] xram_data_in;
  logic          xram_ack;
  logic [1:0]    owner;
  logic          busy;
  logic          auto_ack, man_ack;

  int n_chk = 0;
  int n_err = 0;
  int n_beats, n_ovl;

  // Zero-wait XRAM model: acknowledges whatever strobe it sees.
  assign xram_ack = auto_ack ? xram_stb : man_ack;

  always #5 clk = ~clk;

  xram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .aes_addr(aes_addr), .sha_addr(sha_addr),
    .cpu_data_out(cpu_data_out), .aes_data_out(aes_data_out), .sha_data_out(sha_data_out),
    .cpu_wr(cpu_wr), .aes_wr(aes_wr), .sha_wr(sha_wr),
    .cpu_stb(cpu_stb), .aes_stb(aes_stb), .sha_stb(sha_stb),
    .cpu_ack(cpu_ack), .aes_ack(aes_ack), .sha_ack(sha_ack),
    .req_data_in(req_data_in),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_wr(xram_wr),
    .xram_stb(xram_stb), .xram_data_in(xram_data_in), .xram_ack(xram_ack),
    .owner(owner), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] acks();
    return 32'({sha_ack, aes_ack, cpu_ack});
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    cpu_stb  = 1'b0;
    aes_stb  = 1'b0;
    sha_stb  = 1'b0;
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    smp();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stb", 32'(xram_stb), 0);
    chk("rst_owner", 32'(owner), 0);
    cyc();
    rst = 1'b0;
  endtask

  // Entered in an IDLE cycle with stb(s) up; one beat, requester drops, back to IDLE.
  task automatic grant_one(input string tag, input int exp_own, input logic [AW-1:0] exp_addr);
    cyc();
    smp();
    chk({tag, "_owner"}, 32'(owner), 32'(exp_own));
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_ack"}, acks(), 32'(1 << exp_own));
    chk({tag, "_addr"}, 32'(xram_addr), 32'(exp_addr));
    cyc();
    case (exp_own)
      0: cpu_stb = 1'b0;
      1: aes_stb = 1'b0;
      default: sha_stb = 1'b0;
    endcase
    smp();
    chk({tag, "_drop"}, 32'(xram_stb), 0);
    cyc();
    smp();
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic aes_burst(input bit raise_cpu);
    n_beats = 0;
    n_ovl   = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (raise_cpu && i == 4) cpu_stb = 1'b1;
      smp();
      if (aes_ack) n_beats++;
      if (aes_ack && cpu_ack) n_ovl++;
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = 16'h0040; aes_addr = 16'h1000; sha_addr = 16'h2000;
    cpu_data_out = 8'h11; aes_data_out = 8'h22; sha_data_out = 8'h33;
    cpu_wr = 1'b0; aes_wr = 1'b1; sha_wr = 1'b0;
    xram_data_in = 8'h00;

    // Single CPU read
    do_reset();
    cpu_stb = 1'b1;
    smp();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_stb", 32'(xram_stb), 0);
    cyc();
    man_ack = 1'b1;
    xram_data_in = 8'hA5;
    smp();
    chk("t1_stb", 32'(xram_stb), 1);
    chk("t1_addr", 32'(xram_addr), 32'h0040);
    chk("t1_wr", 32'(xram_wr), 0);
    chk("t1_ack", acks(), 32'b001);
    chk("t1_rdata", 32'(req_data_in), 32'hA5);
    cyc();
    cpu_stb = 1'b0;
    man_ack = 1'b0;
    smp();
    chk("t1_noack", acks(), 0);
    cyc();
    smp();
    chk("t1_back_idle", 32'(busy), 0);

    // Three-way contention from rr_ptr=0
    do_reset();
    auto_ack = 1'b1;
    cpu_stb = 1'b1; aes_stb = 1'b1; sha_stb = 1'b1;
    smp();
    grant_one("t2_cpu", 0, 16'h0040);
    chk("t2_aes_wdata", 32'(aes_data_out), 32'h22);
    grant_one("t2_aes", 1, 16'h1000);
    grant_one("t2_sha", 2, 16'h2000);
    // rr_ptr back at cpu: aes beats sha
    aes_stb = 1'b1; sha_stb = 1'b1;
    grant_one("t2_rr", 1, 16'h1000);
    grant_one("t2_rr_sha", 2, 16'h2000);

    // AES burst with cpu arriving mid-burst
    do_reset();
    auto_ack = 1'b1;
    aes_stb = 1'b1;
    smp();
    aes_burst(1'b1);
    chk("t3_beats", 32'(n_beats), 16);
    chk("t3_overlap", 32'(n_ovl), 0);
    cyc();
    smp();
    chk("t3_idle", 32'(busy), 0);
    cyc();
    smp();
    chk("t3_cpu_owner", 32'(owner), 0);
    chk("t3_cpu_ack", acks(), 32'b001);

    // Owner drops stb without an ack
    do_reset();
    sha_stb = 1'b1;
    smp();
    cyc();
    smp();
    chk("t4_owner", 32'(owner), 2);
    chk("t4_stb", 32'(xram_stb), 1);
    chk("t4_noack", acks(), 0);
    cyc();
    sha_stb = 1'b0;
    smp();
    chk("t4_stb_drop", 32'(xram_stb), 0);
    chk("t4_busy", 32'(busy), 1);
    cyc();
    aes_stb = 1'b1; sha_stb = 1'b1;
    smp();
    chk("t4_idle", 32'(busy), 0);
    cyc();
    smp();
    chk("t4_rr_owner", 32'(owner), 1);

    // Stray ack in IDLE
    do_reset();
    man_ack = 1'b1;
    smp();
    chk("t5_acks", acks(), 0);
    chk("t5_stb", 32'(xram_stb), 0);
    cyc();
    smp();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_acks2", acks(), 0);
    man_ack = 1'b0;

    // Reset during beat 5 of an AES burst
    do_reset();
    auto_ack = 1'b1;
    aes_stb = 1'b1;
    smp();
    for (int i = 0; i < 5; i++) begin
      cyc();
      smp();
    end
    chk("t6_beat5", 32'(aes_ack), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_stb", 32'(xram_stb), 0);
    chk("t6_rst_ack", 32'(aes_ack), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    aes_stb = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    smp();
    chk("t6_no_regrant", 32'(busy), 0);
    aes_stb = 1'b1;
    aes_burst(1'b0);
    chk("t6_full_burst", 32'(n_beats), 16);
    cyc();
    smp();
    chk("t6_end_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
